adder_t: RTL and testbench

ADDER_T -- requirements
Module: adder_t

---
 rtl/adder_t.sv | 149 ++++++++++++++
 tb/tb_adder_t.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/adder_t.sv
// ============================================================================
// Module   : adder_t
// Brief    : Three-PE partial-sum plus membrane accumulator with threshold spike.
// Revision : 1.0
// ============================================================================
`default_nettype none

module adder_t #(
    parameter int WIDTH     = 8,
    parameter int THRESHOLD = 64,
    parameter int FL        = 2,
    parameter int BL        = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pe0_data,
    input  logic [WIDTH-1:0] pe1_data,
    input  logic [WIDTH-1:0] pe2_data,
    input  logic             pe0_valid,
    input  logic             pe1_valid,
    input  logic             pe2_valid,
    output logic             pe0_ready,
    output logic             pe1_ready,
    output logic             pe2_ready,
    input  logic [WIDTH-1:0] mem_in_data,
    input  logic             mem_in_valid,
    output logic             mem_in_ready,
    output logic [WIDTH-1:0] membrane_out,
    output logic             membrane_out_valid,
    input  logic             membrane_out_ready,
    output logic             spike_out,
    output logic             spike_out_valid,
    input  logic             spike_out_ready
);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        DELAY   = 2'd1,
        SEND    = 2'd2,
        BACKOFF = 2'd3
    } state_t;

    localparam int C_CNT_MAX = (FL > BL) ? FL : BL;
    localparam int C_CW      = $clog2(C_CNT_MAX + 2);
    localparam int C_SW      = WIDTH + 2;
    localparam int C_BL_LAST = (BL > 0) ? BL - 1 : 0;

    state_t           r_state;
    logic [C_CW-1:0]  r_cnt;
    logic [3:0]       r_got;
    logic             r_armed;
    logic [WIDTH-1:0] r_pe0;
    logic [WIDTH-1:0] r_pe1;
    logic [WIDTH-1:0] r_pe2;
    logic [WIDTH-1:0] r_mem;
    logic [WIDTH-1:0] r_mem_out;
    logic             r_spike;
    logic             r_mvalid;
    logic             r_svalid;

    logic [3:0]       w_rdy;
    logic [3:0]       w_vld;
    logic [3:0]       w_fire;
    logic [C_SW-1:0]  w_sum;
    logic             w_spike;
    logic             w_m_done;
    logic             w_s_done;

    // r_armed holds readies low until the first edge after reset release.
    assign w_rdy    = (r_armed && (r_state == COLLECT)) ? ~r_got : 4'b0000;
    assign w_vld    = {mem_in_valid, pe2_valid, pe1_valid, pe0_valid};
    assign w_fire   = w_rdy & w_vld;
    assign w_sum    = {2'b00, r_pe0} + {2'b00, r_pe1} + {2'b00, r_pe2} + {2'b00, r_mem};
    assign w_spike  = (w_sum >= C_SW'(THRESHOLD));
    assign w_m_done = !r_mvalid || membrane_out_ready;
    assign w_s_done = !r_svalid || spike_out_ready;

    assign pe0_ready          = w_rdy[0];
    assign pe1_ready          = w_rdy[1];
    assign pe2_ready          = w_rdy[2];
    assign mem_in_ready       = w_rdy[3];
    assign membrane_out       = r_mem_out;
    assign membrane_out_valid = r_mvalid;
    assign spike_out          = r_spike;
    assign spike_out_valid    = r_svalid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= COLLECT;
            r_cnt     <= '0;
            r_got     <= 4'b0000;
            r_armed   <= 1'b0;
            r_pe0     <= '0;
            r_pe1     <= '0;
            r_pe2     <= '0;
            r_mem     <= '0;
            r_mem_out <= '0;
            r_spike   <= 1'b0;
            r_mvalid  <= 1'b0;
            r_svalid  <= 1'b0;
        end else begin
            r_armed <= 1'b1;
            case (r_state)
                COLLECT: begin
                    if (w_fire[0]) r_pe0 <= pe0_data;
                    if (w_fire[1]) r_pe1 <= pe1_data;
                    if (w_fire[2]) r_pe2 <= pe2_data;
                    if (w_fire[3]) r_mem <= mem_in_data;
                    r_got <= r_got | w_fire;
                    if (&(r_got | w_fire)) begin
                        r_state <= DELAY;
                        r_cnt   <= '0;
                    end
                end
                DELAY: begin
                    if (r_cnt == C_CW'(FL)) begin
                        r_state   <= SEND;
                        r_mvalid  <= 1'b1;
                        r_svalid  <= 1'b1;
                        r_spike   <= w_spike;
                        r_mem_out <= w_spike ? '0 : w_sum[WIDTH-1:0];
                    end else begin
                        r_cnt <= r_cnt + C_CW'(1);
                    end
                end
                SEND: begin
                    if (r_mvalid && membrane_out_ready) r_mvalid <= 1'b0;
                    if (r_svalid && spike_out_ready)    r_svalid <= 1'b0;
                    if (w_m_done && w_s_done) begin
                        r_got   <= 4'b0000;
                        r_cnt   <= '0;
                        r_state <= (BL == 0) ? COLLECT : BACKOFF;
                    end
                end
                BACKOFF: begin
                    if (r_cnt == C_CW'(C_BL_LAST)) begin
                        r_state <= COLLECT;
                    end else begin
                        r_cnt <= r_cnt + C_CW'(1);
                    end
                end
                default: r_state <= COLLECT;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_adder_t.sv
// ============================================================================
// Module   : tb_adder_t
// Brief    : Directed self-checking bench for adder_t (WIDTH=8, THR=64, FL=BL=2).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_adder_t;

    logic       clk;
    logic       rst;
    logic [7:0] pe0_data, pe1_data, pe2_data, mem_in_data;
    logic       pe0_valid, pe1_valid, pe2_valid, mem_in_valid;
    logic       pe0_ready, pe1_ready, pe2_ready, mem_in_ready;
    logic [7:0] membrane_out;
    logic       membrane_out_valid, membrane_out_ready;
    logic       spike_out, spike_out_valid, spike_out_ready;

    int n_tests = 0;
    int n_fail  = 0;

    adder_t #(.WIDTH(8), .THRESHOLD(64), .FL(2), .BL(2)) u_dut (
        .clk                (clk),
        .rst                (rst),
        .pe0_data           (pe0_data),
        .pe1_data           (pe1_data),
        .pe2_data           (pe2_data),
        .pe0_valid          (pe0_valid),
        .pe1_valid          (pe1_valid),
        .pe2_valid          (pe2_valid),
        .pe0_ready          (pe0_ready),
        .pe1_ready          (pe1_ready),
        .pe2_ready          (pe2_ready),
        .mem_in_data        (mem_in_data),
        .mem_in_valid       (mem_in_valid),
        .mem_in_ready       (mem_in_ready),
        .membrane_out       (membrane_out),
        .membrane_out_valid (membrane_out_valid),
        .membrane_out_ready (membrane_out_ready),
        .spike_out          (spike_out),
        .spike_out_valid    (spike_out_valid),
        .spike_out_ready    (spike_out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered one ns after an edge with the block in COLLECT. Offers a junk
    // pe0 beat during DELAY, which must not disturb the result.
    task automatic run_txn(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                           input logic [7:0] m, input logic [7:0] em, input logic es,
                           input string tag);
        check({tag, "_rdy_pre"}, {pe0_ready, pe1_ready, pe2_ready, mem_in_ready}, 4'b1111);
        pe0_data = a; pe1_data = b; pe2_data = c; mem_in_data = m;
        pe0_valid = 1; pe1_valid = 1; pe2_valid = 1; mem_in_valid = 1;
        tick();
        pe1_valid = 0; pe2_valid = 0; mem_in_valid = 0;
        pe0_data = 8'hAA;
        check({tag, "_rdy_delay"}, {pe0_ready, mem_in_ready}, 2'b00);
        tick();
        check({tag, "_vld_e1"}, {membrane_out_valid, spike_out_valid}, 2'b00);
        tick();
        check({tag, "_vld_e2"}, {membrane_out_valid, spike_out_valid}, 2'b00);
        tick();
        pe0_valid = 0;
        check({tag, "_vld_e3"}, {membrane_out_valid, spike_out_valid}, 2'b11);
        check({tag, "_mem"}, membrane_out, em);
        check({tag, "_spk"}, spike_out, es);
        membrane_out_ready = 1; spike_out_ready = 1;
        tick();
        membrane_out_ready = 0; spike_out_ready = 0;
        check({tag, "_vld_taken"}, {membrane_out_valid, spike_out_valid}, 2'b00);
        check({tag, "_bo1"}, pe0_ready, 0);
        tick();
        check({tag, "_bo2"}, pe0_ready, 0);
        tick();
        check({tag, "_rdy_post"}, {pe0_ready, pe1_ready, pe2_ready, mem_in_ready}, 4'b1111);
    endtask

    initial begin
        rst = 1;
        pe0_data = 0; pe1_data = 0; pe2_data = 0; mem_in_data = 0;
        pe0_valid = 0; pe1_valid = 0; pe2_valid = 0; mem_in_valid = 0;
        membrane_out_ready = 0; spike_out_ready = 0;

        repeat (2) tick();
        check("rst_rdy", {pe0_ready, pe1_ready, pe2_ready, mem_in_ready}, 4'b0000);
        check("rst_vld", {membrane_out_valid, spike_out_valid}, 2'b00);
        check("rst_out", {membrane_out, spike_out}, 9'd0);
        rst = 0;
        #1;
        check("rel_rdy_pre_edge", pe0_ready, 0);
        tick();
        check("rel_rdy_first_edge", {pe0_ready, pe1_ready, pe2_ready, mem_in_ready}, 4'b1111);

        run_txn(8'd10,  8'd20,  8'd5,   8'd12,  8'd47, 1'b0, "sum47");
        run_txn(8'd31,  8'd31,  8'd31,  8'd0,   8'd0,  1'b1, "sum93");
        run_txn(8'd20,  8'd20,  8'd20,  8'd4,   8'd0,  1'b1, "sum64");
        run_txn(8'd20,  8'd20,  8'd20,  8'd3,   8'd63, 1'b0, "sum63");
        run_txn(8'd255, 8'd255, 8'd255, 8'd255, 8'd0,  1'b1, "sum1020");

        // Staggered inputs (sum 65) with the spike channel stalled.
        pe0_data = 8'd30; pe0_valid = 1;
        tick();
        pe0_valid = 0;
        check("stag_pe0_done", pe0_ready, 0);
        check("stag_pe1_open", pe1_ready, 1);
        pe1_data = 8'd30; pe1_valid = 1;
        tick();
        pe1_valid = 0;
        pe2_data = 8'd3; pe2_valid = 1;
        tick();
        pe2_valid = 0;
        check("stag_mem_open", mem_in_ready, 1);
        mem_in_data = 8'd2; mem_in_valid = 1;
        tick();
        mem_in_valid = 0;
        check("stag_rdy_delay", {pe0_ready, pe1_ready, pe2_ready, mem_in_ready}, 4'b0000);
        repeat (2) tick();
        check("stag_vld_early", membrane_out_valid, 0);
        tick();
        check("stag_vld", {membrane_out_valid, spike_out_valid}, 2'b11);
        membrane_out_ready = 1;
        tick();
        membrane_out_ready = 0;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("stag_hold_vld%0d", k), {membrane_out_valid, spike_out_valid}, 2'b01);
            check($sformatf("stag_hold_spk%0d", k), spike_out, 1);
            check($sformatf("stag_hold_rdy%0d", k), pe0_ready, 0);
            if (k < 4) tick();
        end
        check("stag_hold_mem", membrane_out, 0);
        spike_out_ready = 1;
        tick();
        spike_out_ready = 0;
        check("stag_spk_taken", spike_out_valid, 0);
        check("stag_bo1", pe0_ready, 0);
        tick();
        check("stag_bo2", pe0_ready, 0);
        tick();
        check("stag_rdy_post", {pe0_ready, pe1_ready, pe2_ready, mem_in_ready}, 4'b1111);

        // Reset after a partial capture must discard it.
        pe0_data = 8'd100; pe0_valid = 1;
        mem_in_data = 8'd100; mem_in_valid = 1;
        tick();
        pe0_valid = 0; mem_in_valid = 0;
        check("part_flags", {pe0_ready, pe1_ready, pe2_ready, mem_in_ready}, 4'b0110);
        rst = 1;
        #2;
        check("mid_rst_rdy", {pe0_ready, pe1_ready, pe2_ready, mem_in_ready}, 4'b0000);
        check("mid_rst_out", {membrane_out_valid, spike_out_valid, spike_out, membrane_out}, 11'd0);
        rst = 0;
        tick();
        run_txn(8'd1, 8'd2, 8'd3, 8'd4, 8'd10, 1'b0, "after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
